dcache_responder: RTL

- Memory-side responder for the core's data-cache request interface. It is the other end of dcache_addr / dcache_req_valid / dcache_wen / dcache_wdata / dcache_wlen, and it produces dcache_ready / dcache_data_valid / dcache_data.
- Backs requests with an on-chip word-addressed RAM and a fixed, parameterised response latency. Used in simulation and on FPGA in place of a real cache.
- Optionally decodes a store window onto the VMEM write port.

---
 rtl/dcache_responder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dcache_responder.sv
//==============================================================================
// Module      : dcache_responder
// Description : Memory-side responder for the data-cache request interface.
//               Requests are served from an on-chip word-addressed RAM and
//               answered after a fixed latency. Optional store window onto the
//               VMEM write port, enabled by defining DCACHE_RESP_VGA_MMIO_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dcache_responder #(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 64,
    parameter int          DEPTH    = 4096,
    parameter int          LAT      = 2,
    parameter logic [31:0] VGA_BASE = 32'h1000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wen_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [1:0]        wlen_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic              data_valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [9:0]        vga_waddr_h_o,
    output logic [8:0]        vga_waddr_v_o,
    output logic              vga_we_o,
    output logic [23:0]       vga_wdata_o
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [1:0] c_ST_RST_WAIT = 2'd0;
    localparam logic [1:0] c_ST_IDLE     = 2'd1;
    localparam logic [1:0] c_ST_BUSY     = 2'd2;
    localparam logic [1:0] c_ST_RESP     = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               r_ready;
    logic               r_data_valid;
    logic [DATA_W-1:0]  r_data;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_ready_next;
    logic               w_data_valid_next;
    logic [DATA_W-1:0]  w_data_next;
    logic [c_CNT_W-1:0] w_cnt_next;

    logic               w_accept;
    logic               w_in_vga;
    logic               w_ram_we;
    logic [c_IDX_W-1:0] w_idx;
    logic [2:0]         w_off;
    logic [7:0]         w_size_mask;
    logic [7:0]         w_be;
    logic [DATA_W-1:0]  w_wdata_sh;
    logic               w_unused;

    logic [DATA_W-1:0]  r_mem [DEPTH];

    assign w_accept = req_valid_i && r_ready;
    assign w_idx    = addr_i[3 +: c_IDX_W];
    assign w_ram_we = w_accept && wen_i && !w_in_vga;

    // Offset is forced to the natural alignment of the access size.
    always_comb begin
        w_size_mask = 8'h01;
        w_off       = addr_i[2:0];
        case (wlen_i)
            2'b00: begin w_size_mask = 8'h01; w_off = addr_i[2:0];        end
            2'b01: begin w_size_mask = 8'h03; w_off = {addr_i[2:1], 1'b0}; end
            2'b10: begin w_size_mask = 8'h0F; w_off = {addr_i[2], 2'b00};  end
            default: begin w_size_mask = 8'hFF; w_off = 3'b000;           end
        endcase
    end

    assign w_be       = w_size_mask << w_off;
    assign w_wdata_sh = wdata_i << {w_off, 3'b000};

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int b = 0; b < 8; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_RST_WAIT;
            r_ready      <= 1'b0;
            r_data_valid <= 1'b0;
            r_data       <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_ready      <= w_ready_next;
            r_data_valid <= w_data_valid_next;
            r_data       <= w_data_next;
            r_cnt        <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_RST_WAIT: w_state_next = c_ST_IDLE;
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (LAT == 1) ? c_ST_RESP : c_ST_BUSY;
                end
            end
            c_ST_BUSY: begin
                if (flush_i) begin
                    w_state_next = c_ST_IDLE;
                end else if (r_cnt == c_CNT_W'(1)) begin
                    w_state_next = c_ST_RESP;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // Ready and the response pulse follow directly from the state being entered.
    always_comb begin
        w_ready_next      = (w_state_next == c_ST_IDLE);
        w_data_valid_next = (w_state_next == c_ST_RESP);
        w_data_next       = r_data;
        w_cnt_next        = r_cnt;
        if (r_state == c_ST_IDLE && w_accept) begin
            w_cnt_next  = c_CNT_W'(LAT - 1);
            w_data_next = (wen_i || w_in_vga) ? '0 : r_mem[w_idx];
        end else if (r_state == c_ST_BUSY) begin
            w_cnt_next = r_cnt - c_CNT_W'(1);
        end
    end

    assign ready_o      = r_ready;
    assign data_valid_o = r_data_valid;
    assign data_o       = r_data;

`ifdef DCACHE_RESP_VGA_MMIO_EN
    logic [ADDR_W-1:0] w_vga_rel;
    logic              r_vga_we;
    logic [9:0]        r_vga_h;
    logic [8:0]        r_vga_v;
    logic [23:0]       r_vga_d;

    assign w_vga_rel = addr_i - ADDR_W'(VGA_BASE);
    assign w_in_vga  = (addr_i >= ADDR_W'(VGA_BASE)) && (w_vga_rel[ADDR_W-1:21] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vga_we <= 1'b0;
            r_vga_h  <= '0;
            r_vga_v  <= '0;
            r_vga_d  <= '0;
        end else begin
            r_vga_we <= w_accept && wen_i && w_in_vga;
            if (w_accept && wen_i && w_in_vga) begin
                r_vga_h <= addr_i[11:2];
                r_vga_v <= addr_i[20:12];
                r_vga_d <= wdata_i[23:0];
            end
        end
    end

    assign vga_we_o      = r_vga_we;
    assign vga_waddr_h_o = r_vga_h;
    assign vga_waddr_v_o = r_vga_v;
    assign vga_wdata_o   = r_vga_d;
    assign w_unused      = ^addr_i;
`else
    assign w_in_vga      = 1'b0;
    assign vga_we_o      = 1'b0;
    assign vga_waddr_h_o = '0;
    assign vga_waddr_v_o = '0;
    assign vga_wdata_o   = '0;
    assign w_unused      = ^{addr_i, VGA_BASE};
`endif

endmodule

`default_nettype wire
